// File: rtl/ft232h_sync_tx_burst_if.sv
// FT232H synchronous-245 transmit bus plus TX FIFO read port, grouped for the burst engine.
// master = transmit engine side, slave = FT232H/FIFO environment side.
interface ft232h_sync_tx_burst_if #(
    parameter int DATA_W  = 8,
    parameter int LEVEL_W = 17
);
    logic               txe_n;
    logic               rd_n;
    logic               wr_n;
    logic [DATA_W-1:0]  data_out;
    logic               data_oe;
    logic               fifo_rd_en;
    logic [DATA_W-1:0]  fifo_data;
    logic               fifo_empty;
    logic [LEVEL_W-1:0] rdusedw;

    modport master (
        input  txe_n, rd_n, fifo_data, fifo_empty, rdusedw,
        output wr_n, data_out, data_oe, fifo_rd_en
    );

    modport slave (
        output txe_n, rd_n, fifo_data, fifo_empty, rdusedw,
        input  wr_n, data_out, data_oe, fifo_rd_en
    );
endinterface

// File: rtl/ft232h_sync_tx_burst.sv
// FT232H sync-245 transmit engine: threshold/flush-triggered bursts from the TX FIFO through a
// small skid buffer, so txe_n stalls and receive-side bus yields never lose or repeat a byte.
module ft232h_sync_tx_burst #(
    parameter int DATA_W        = 8,
    parameter int LEVEL_W       = 17,
    parameter int THRESHOLD     = 66048,
    parameter int BURST_LEN     = 512,
    parameter int FLUSH_TIMEOUT = 65535,
    parameter int SKID_DEPTH    = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    ft232h_sync_tx_burst_if.master bus,
    output logic                  busy,
    output logic [31:0]           tx_count
);
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RI_W  = $clog2(BURST_LEN + 1);
    localparam int TMR_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam bit FLUSH_EN = (FLUSH_TIMEOUT != 0);

    localparam logic [LEVEL_W-1:0] THRESH_L = LEVEL_W'(THRESHOLD);
    localparam logic [RI_W-1:0]    BURST_L  = RI_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]   DEPTH_L  = CNT_W'(SKID_DEPTH);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BURST, YIELD, GAP} state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   skid_count;
    logic               vld_p1;
    logic [RI_W-1:0]    reads_issued;
    logic [TMR_W-1:0]   flush_timer;
    logic               flush_due;

    logic               accept;
    logic               rd_go;
    logic               flush_qual;
    logic               burst_done;
    logic               wr_go;
    logic [CNT_W-1:0]   cnt_after_pop;
    logic [CNT_W-1:0]   cnt_next;
    logic [DATA_W-1:0]  head_next;

    always_comb begin
        accept        = !bus.wr_n && !bus.txe_n;
        rd_go         = (state == BURST) && bus.rd_n && !bus.txe_n && !bus.fifo_empty &&
                        (reads_issued < BURST_L) &&
                        ((skid_count + CNT_W'(vld_p1)) < DEPTH_L);
        cnt_after_pop = skid_count - CNT_W'(accept);
        cnt_next      = cnt_after_pop + CNT_W'(vld_p1);
        // When the pop empties the skid, the byte landing this edge becomes the new head.
        head_next     = (cnt_after_pop == '0) ? bus.fifo_data
                                              : skid_mem[rd_ptr + PTR_W'(accept)];
        flush_qual    = (bus.rdusedw != '0) && (bus.rdusedw < THRESH_L);
        burst_done    = (skid_count == '0) && !vld_p1 &&
                        ((reads_issued == BURST_L) || bus.fifo_empty);
        state_next    = state;
        case (state)
            IDLE:    if (!bus.txe_n && bus.rd_n && ((bus.rdusedw >= THRESH_L) || flush_due))
                         state_next = BURST;
            BURST:   if (!bus.rd_n)      state_next = YIELD;
                     else if (burst_done) state_next = GAP;
            YIELD:   if (bus.rd_n)       state_next = BURST;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        wr_go = (state == BURST) && bus.rd_n && (cnt_next != '0);
    end

    assign bus.fifo_rd_en = rd_go;

    // Skid storage: data only, written one cycle after the FIFO read strobe.
    always_ff @(posedge clock) begin
        if (vld_p1) skid_mem[wr_ptr] <= bus.fifo_data;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            skid_count   <= '0;
            vld_p1       <= 1'b0;
            reads_issued <= '0;
            flush_timer  <= '0;
            flush_due    <= 1'b0;
            bus.wr_n     <= 1'b1;
            bus.data_oe  <= 1'b0;
            bus.data_out <= '0;
            tx_count     <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);

            // FIFO read stage -> skid push stage
            vld_p1 <= rd_go;
            if (vld_p1) wr_ptr <= wr_ptr + 1'b1;
            if (accept) begin
                rd_ptr   <= rd_ptr + 1'b1;
                tx_count <= tx_count + 32'd1;
            end
            skid_count <= cnt_next;

            // Skid head -> registered bus stage
            bus.wr_n    <= !wr_go;
            bus.data_oe <= wr_go;
            if (wr_go) bus.data_out <= head_next;

            if ((state == IDLE) && (state_next == BURST)) begin
                reads_issued <= '0;
                flush_timer  <= '0;
                flush_due    <= 1'b0;
            end else begin
                if (rd_go) reads_issued <= reads_issued + 1'b1;
                if ((state == IDLE) && flush_qual) begin
                    if (FLUSH_EN && (flush_timer == TMR_LAST)) flush_due <= 1'b1;
                    else flush_timer <= flush_timer + 1'b1;
                end else begin
                    flush_timer <= '0;
                    flush_due   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ft232h_sync_tx_burst.sv
// Directed bench for ft232h_sync_tx_burst: normal bursts, txe_n stall, flush timeout,
// receive-side yield, mid-burst reset, and a flush-disabled instance that must stay silent.
module tb_ft232h_sync_tx_burst;
    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy1, busy0;
    logic [31:0] txc1, txc0;

    always #5 clock = ~clock;

    ft232h_sync_tx_burst_if #(.DATA_W(8), .LEVEL_W(17)) bus1 ();
    ft232h_sync_tx_burst_if #(.DATA_W(8), .LEVEL_W(17)) bus0 ();

    ft232h_sync_tx_burst #(.FLUSH_TIMEOUT(1000)) dut (
        .clock(clock), .rst_n(rst_n), .bus(bus1), .busy(busy1), .tx_count(txc1)
    );

    ft232h_sync_tx_burst #(.FLUSH_TIMEOUT(0)) dut_nf (
        .clock(clock), .rst_n(rst_n), .bus(bus0), .busy(busy0), .tx_count(txc0)
    );

    // TX FIFO model: read data valid one cycle after fifo_rd_en
    logic [7:0]  fmem [0:4095];
    logic [11:0] fq_wr = '0;
    logic [11:0] fq_rd = '0;
    assign bus1.fifo_empty = (fq_rd == fq_wr);

    always @(posedge clock) begin
        if (bus1.fifo_rd_en && (fq_rd != fq_wr)) begin
            bus1.fifo_data <= fmem[fq_rd];
            fq_rd          <= fq_rd + 12'd1;
        end
    end

    // Bus monitor: log every byte the FT232H side accepts
    logic [7:0] acc_log [0:4095];
    int         acc_cyc [0:4095];
    int         acc_n = 0;
    int         rd_cnt = 0;
    int         cyc = 0;
    int         max_occ = 0;
    int         nf_wr_bad = 0;
    int         nf_rd_bad = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rst_n && !bus1.wr_n && !bus1.txe_n) begin
            acc_log[acc_n] <= bus1.data_out;
            acc_cyc[acc_n] <= cyc;
            acc_n          <= acc_n + 1;
        end
        if (rst_n && bus1.fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (rst_n && !bus0.wr_n) nf_wr_bad <= nf_wr_bad + 1;
        if (rst_n && bus0.fifo_rd_en) nf_rd_bad <= nf_rd_bad + 1;
    end

    always @(negedge clock) begin
        if (rst_n && (rd_cnt - acc_n > max_occ)) max_occ <= rd_cnt - acc_n;
    end

    int errors = 0;
    int checks = 0;
    int exp_tx = 0;

    task automatic load_fifo(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[fq_wr] = 8'(i);
            fq_wr = fq_wr + 12'd1;
        end
    endtask

    task automatic wait_rd(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (bus1.fifo_rd_en) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (!busy1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_present(input int base, input int idx, input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (!bus1.wr_n && (acc_n - base == idx)) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus1.txe_n = 1'b1; bus1.rd_n = 1'b1; bus1.rdusedw = '0; bus1.fifo_data = '0;
        bus0.txe_n = 1'b0; bus0.rd_n = 1'b1; bus0.rdusedw = 17'd66047;
        bus0.fifo_empty = 1'b0; bus0.fifo_data = 8'hA5;
        repeat (3) @(negedge clock);
        checks++; if (bus1.wr_n !== 1'b1) begin errors++; $display("FAIL reset_wr_n: got %b want 1", bus1.wr_n); end
        checks++; if (bus1.data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", bus1.data_oe); end
        checks++; if (bus1.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus1.fifo_rd_en); end
        checks++; if (bus1.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", bus1.data_out); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy1); end
        checks++; if (txc1 !== 32'd0) begin errors++; $display("FAIL reset_tx_count: got %0d want 0", txc1); end
        rst_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic_burst;
        int base, bad;
        bit seen, ok;
        base = acc_n;
        load_fifo(512);
        bus1.rdusedw = 17'd66048; bus1.txe_n = 1'b0; bus1.rd_n = 1'b1;
        wait_rd(2, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_rd_latency: got none want fifo_rd_en within 2 cycles"); end
        bus1.rdusedw = '0;
        wait_idle(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_idle_timeout: got busy want idle"); end
        exp_tx += 512;
        checks++; if (acc_n - base !== 512) begin errors++; $display("FAIL basic_count: got %0d want 512", acc_n - base); end
        bad = 0;
        for (int i = 0; i < 512; i++) if (acc_log[base + i] !== 8'(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_order: got %0d bad bytes want 0", bad); end
        checks++; if (acc_cyc[base + 511] - acc_cyc[base] !== 511) begin
            errors++; $display("FAIL basic_continuous: got span %0d want 511", acc_cyc[base + 511] - acc_cyc[base]); end
        checks++; if (txc1 !== 32'(exp_tx)) begin errors++; $display("FAIL basic_tx_count: got %0d want %0d", txc1, exp_tx); end
        checks++; if (bus1.wr_n !== 1'b1) begin errors++; $display("FAIL basic_gap_wr_n: got %b want 1", bus1.wr_n); end
    endtask

    task automatic test_txe_stall;
        int base, bad, stall_bad;
        bit seen, ok, found;
        base = acc_n;
        load_fifo(512);
        bus1.rdusedw = 17'd66048;
        wait_rd(2, seen);
        bus1.rdusedw = '0;
        wait_present(base, 100, 400, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL stall_find_byte100: got not presented want presented"); end
        checks++; if (bus1.data_out !== 8'd100) begin errors++; $display("FAIL stall_present: got %0d want 100", bus1.data_out); end
        bus1.txe_n = 1'b1;
        stall_bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus1.wr_n !== 1'b0 || bus1.data_out !== 8'd100 || bus1.fifo_rd_en !== 1'b0) stall_bad++;
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); end
        bus1.txe_n = 1'b0;
        wait_idle(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_idle_timeout: got busy want idle"); end
        exp_tx += 512;
        checks++; if (acc_n - base !== 512) begin errors++; $display("FAIL stall_count: got %0d want 512", acc_n - base); end
        bad = 0;
        for (int i = 0; i < 512; i++) if (acc_log[base + i] !== 8'(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_order: got %0d bad bytes want 0", bad); end
        checks++; if (max_occ > 4) begin errors++; $display("FAIL stall_occupancy: got %0d want <=4", max_occ); end
        checks++; if (txc1 !== 32'(exp_tx)) begin errors++; $display("FAIL stall_tx_count: got %0d want %0d", txc1, exp_tx); end
    endtask

    task automatic test_flush;
        int base, bad, quiet_bad;
        bit seen, ok;
        base = acc_n;
        load_fifo(10);
        bus1.rdusedw = 17'd10;
        quiet_bad = 0;
        repeat (999) begin
            @(negedge clock);
            if (bus1.wr_n !== 1'b1 || bus1.fifo_rd_en !== 1'b0) quiet_bad++;
        end
        checks++; if (quiet_bad !== 0) begin errors++; $display("FAIL flush_early: got %0d active cycles want 0", quiet_bad); end
        wait_rd(20, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL flush_start: got no read want read after timeout"); end
        bus1.rdusedw = '0;
        wait_idle(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flush_idle_timeout: got busy want idle"); end
        exp_tx += 10;
        checks++; if (acc_n - base !== 10) begin errors++; $display("FAIL flush_count: got %0d want 10", acc_n - base); end
        bad = 0;
        for (int i = 0; i < 10; i++) if (acc_log[base + i] !== 8'(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL flush_order: got %0d bad bytes want 0", bad); end
        checks++; if (txc1 !== 32'(exp_tx)) begin errors++; $display("FAIL flush_tx_count: got %0d want %0d", txc1, exp_tx); end
    endtask

    task automatic test_yield;
        int base, bad, yield_bad;
        bit seen, ok, found;
        base = acc_n;
        load_fifo(512);
        bus1.rdusedw = 17'd66048;
        wait_rd(2, seen);
        bus1.rdusedw = '0;
        wait_present(base, 199, 400, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL yield_find_byte199: got not presented want presented"); end
        bus1.rd_n = 1'b0;
        @(negedge clock);
        checks++; if (bus1.wr_n !== 1'b1 || bus1.data_oe !== 1'b0) begin
            errors++; $display("FAIL yield_release: got wr_n=%b oe=%b want wr_n=1 oe=0", bus1.wr_n, bus1.data_oe); end
        yield_bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus1.fifo_rd_en !== 1'b0 || bus1.wr_n !== 1'b1 || bus1.data_oe !== 1'b0) yield_bad++;
        end
        checks++; if (yield_bad !== 0) begin errors++; $display("FAIL yield_hold: got %0d bad cycles want 0", yield_bad); end
        bus1.rd_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (!bus1.wr_n) begin found = 1'b1; break; end
        end
        checks++; if (found !== 1'b1 || bus1.data_out !== 8'd200 || acc_n - base !== 200) begin
            errors++; $display("FAIL yield_resume: got byte %0d after %0d accepts want byte 200 after 200", bus1.data_out, acc_n - base); end
        wait_idle(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL yield_idle_timeout: got busy want idle"); end
        exp_tx += 512;
        bad = 0;
        for (int i = 0; i < 512; i++) if (acc_log[base + i] !== 8'(i)) bad++;
        checks++; if (acc_n - base !== 512 || bad !== 0) begin
            errors++; $display("FAIL yield_stream: got %0d bytes %0d bad want 512 bytes 0 bad", acc_n - base, bad); end
        checks++; if (txc1 !== 32'(exp_tx)) begin errors++; $display("FAIL yield_tx_count: got %0d want %0d", txc1, exp_tx); end
    endtask

    task automatic test_reset_mid_burst;
        int base, base2, bad, k0, remain;
        bit seen, ok, found;
        base = acc_n;
        load_fifo(512);
        bus1.rdusedw = 17'd66048;
        wait_rd(2, seen);
        wait_present(base, 300, 600, found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_find_byte300: got not presented want presented"); end
        rst_n = 1'b0;
        @(negedge clock);
        checks++; if (bus1.wr_n !== 1'b1 || bus1.data_oe !== 1'b0 || bus1.fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl: got wr_n=%b oe=%b rd_en=%b want 1 0 0", bus1.wr_n, bus1.data_oe, bus1.fifo_rd_en); end
        checks++; if (bus1.data_out !== 8'h00 || busy1 !== 1'b0 || txc1 !== 32'd0) begin
            errors++; $display("FAIL rst_mid_state: got data=%h busy=%b tx=%0d want 00 0 0", bus1.data_out, busy1, txc1); end
        k0 = int'(fq_rd);
        remain = int'(fq_wr) - k0;
        base2 = acc_n;
        rst_n = 1'b1;
        wait_rd(4, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_restart: got no read want restart"); end
        bus1.rdusedw = '0;
        wait_idle(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_idle_timeout: got busy want idle"); end
        bad = 0;
        for (int i = 0; i < remain; i++) if (acc_log[base2 + i] !== fmem[12'(k0 + i)]) bad++;
        checks++; if (acc_n - base2 !== remain || bad !== 0) begin
            errors++; $display("FAIL rst_stream: got %0d bytes %0d bad want %0d bytes 0 bad", acc_n - base2, bad, remain); end
        checks++; if (txc1 !== 32'(remain)) begin errors++; $display("FAIL rst_tx_count: got %0d want %0d", txc1, remain); end
    endtask

    task automatic test_no_flush;
        repeat (5000) @(negedge clock);
        checks++; if (nf_wr_bad !== 0) begin errors++; $display("FAIL noflush_wr_n: got %0d low cycles want 0", nf_wr_bad); end
        checks++; if (nf_rd_bad !== 0) begin errors++; $display("FAIL noflush_rd_en: got %0d read cycles want 0", nf_rd_bad); end
        checks++; if (busy0 !== 1'b0 || txc0 !== 32'd0) begin
            errors++; $display("FAIL noflush_state: got busy=%b tx=%0d want 0 0", busy0, txc0); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_burst();
        test_txe_stall();
        test_flush();
        test_yield();
        test_reset_mid_burst();
        test_no_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
